// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle core: opcodes, NOP encoding,
// fetch-state and halt-cause codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // sll $0,$0,0 -- decodes as a harmless no-op
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        HC_NONE        = 2'b00,
        HC_INVALID     = 2'b01,
        HC_MISALIGN_JR = 2'b10
    } halt_cause_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs from ControlUnit, instruction-memory port,
// decoded fields and status outputs.
interface fetch_unit_if #(
    parameter int IMEM_ADDR_W = 10
);
    logic                   Stall;
    logic                   BranchEq;
    logic                   BranchNeq;
    logic                   Jump;
    logic                   JumpReg;
    logic                   InvalidInst;
    logic                   Zero;
    logic [31:0]            RegRs;
    logic [IMEM_ADDR_W-1:0] InstAddr;
    logic [31:0]            InstData;
    logic [5:0]             OpCode;
    logic [5:0]             Funct;
    logic [4:0]             Rs;
    logic [4:0]             Rt;
    logic [4:0]             Rd;
    logic [4:0]             Shamt;
    logic [15:0]            Imm;
    logic [31:0]            PC;
    logic [31:0]            PCPlus4;
    logic                   Halted;
    logic [1:0]             HaltCause;
    logic [31:0]            InstCount;

    modport master (
        output Stall, BranchEq, BranchNeq, Jump, JumpReg, InvalidInst, Zero, RegRs, InstData,
        input  InstAddr, OpCode, Funct, Rs, Rt, Rd, Shamt, Imm, PC, PCPlus4,
        input  Halted, HaltCause, InstCount
    );

    modport slave (
        input  Stall, BranchEq, BranchNeq, Jump, JumpReg, InvalidInst, Zero, RegRs, InstData,
        output InstAddr, OpCode, Funct, Rs, Rt, Rd, Shamt, Imm, PC, PCPlus4,
        output Halted, HaltCause, InstCount
    );
endinterface

// File: rtl/pc_next_logic.sv
// Next-PC selection: jr > j > taken branch > sequential.
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] jidx_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] reg_rs_i,
    input  logic        branch_eq_i,
    input  logic        branch_neq_i,
    input  logic        jump_i,
    input  logic        jump_reg_i,
    input  logic        zero_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);
    logic taken;

    assign pc_plus4_o = pc_i + 32'd4;
    assign taken      = (branch_eq_i & zero_i) | (branch_neq_i & ~zero_i);

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jump_reg_i)
            next_pc_o = reg_rs_i;
        else if (jump_i)
            next_pc_o = {pc_plus4_o[31:28], jidx_i, 2'b00};
        else if (taken)
            next_pc_o = pc_plus4_o + branch_offset(imm_i);
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, run/halt state, retired-instruction counter
// and field slicing of the issued instruction.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          IMEM_ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);
    fetch_state_e state_q;
    logic [31:0]  pc_q, cnt_q, cnt_d, pc_d, pc_plus4;
    logic [1:0]   cause_q;
    logic [31:0]  issued;
    logic         jr_misaligned;

    pc_next_logic u_pc_next (
        .pc_i         (pc_q),
        .jidx_i       (bus.InstData[25:0]),
        .imm_i        (bus.InstData[15:0]),
        .reg_rs_i     (bus.RegRs),
        .branch_eq_i  (bus.BranchEq),
        .branch_neq_i (bus.BranchNeq),
        .jump_i       (bus.Jump),
        .jump_reg_i   (bus.JumpReg),
        .zero_i       (bus.Zero),
        .pc_plus4_o   (pc_plus4),
        .next_pc_o    (pc_d)
    );

    assign jr_misaligned = bus.JumpReg & (|bus.RegRs[1:0]);
    assign cnt_d         = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

    // Offending instruction keeps its PC and is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            cause_q <= HC_NONE;
        end else if (!bus.Stall && state_q == RUN) begin
            if (bus.InvalidInst) begin
                state_q <= HALT;
                cause_q <= HC_INVALID;
            end else if (jr_misaligned) begin
                state_q <= HALT;
                cause_q <= HC_MISALIGN_JR;
            end else begin
                pc_q  <= pc_d;
                cnt_q <= cnt_d;
            end
        end
    end

    assign issued        = (state_q == HALT) ? NOP_INST : bus.InstData;
    assign bus.OpCode    = issued[31:26];
    assign bus.Rs        = issued[25:21];
    assign bus.Rt        = issued[20:16];
    assign bus.Rd        = issued[15:11];
    assign bus.Shamt     = issued[10:6];
    assign bus.Funct     = issued[5:0];
    assign bus.Imm       = issued[15:0];
    assign bus.InstAddr  = pc_q[IMEM_ADDR_W+1:2];
    assign bus.PC        = pc_q;
    assign bus.PCPlus4   = pc_plus4;
    assign bus.Halted    = (state_q == HALT);
    assign bus.HaltCause = cause_q;
    assign bus.InstCount = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences and random
// stimulus against a behavioural model of the fetch rules.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.IMEM_ADDR_W(10)) ifc ();
    fetch_unit #(.RESET_PC(32'h0), .IMEM_ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    int checks = 0, failures = 0;

    logic [31:0] m_pc, m_cnt;
    logic        m_halt;
    logic [1:0]  m_cause;

    typedef struct {
        logic rst, stall, beq, bne, j, jr, inv, zero;
        logic [31:0] rs, inst;
        logic [31:0] e_pc;
        logic        e_halt;
        logic [1:0]  e_cause;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t tbl[$];

    localparam logic [31:0] ADD  = 32'h0109_5020;
    localparam logic [31:0] BEQM = 32'h1000_FFFE;
    localparam logic [31:0] BNE4 = 32'h1400_0004;
    localparam logic [31:0] J40  = 32'h0800_0040;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, beq, bne, j, jr, inv, z, input logic [31:0] rs, inst);
        rst = r; ifc.Stall = s; ifc.BranchEq = beq; ifc.BranchNeq = bne; ifc.Jump = j;
        ifc.JumpReg = jr; ifc.InvalidInst = inv; ifc.Zero = z; ifc.RegRs = rs; ifc.InstData = inst;
    endtask

    function automatic vec_t mk(input logic r, s, beq, bne, j, jr, inv, z,
                                input logic [31:0] rs, inst, pc, input logic h,
                                input logic [1:0] c, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.stall = s; v.beq = beq; v.bne = bne; v.j = j; v.jr = jr; v.inv = inv;
        v.zero = z; v.rs = rs; v.inst = inst; v.e_pc = pc; v.e_halt = h; v.e_cause = c; v.e_cnt = cnt;
        return v;
    endfunction

    // Combinational outputs predicted from model state and current inputs.
    task automatic check_comb();
        logic [31:0] iss;
        iss = m_halt ? 32'h0 : ifc.InstData;
        chk("OpCode",    32'(ifc.OpCode),    32'(iss[31:26]));
        chk("Rs",        32'(ifc.Rs),        32'(iss[25:21]));
        chk("Rt",        32'(ifc.Rt),        32'(iss[20:16]));
        chk("Rd",        32'(ifc.Rd),        32'(iss[15:11]));
        chk("Shamt",     32'(ifc.Shamt),     32'(iss[10:6]));
        chk("Funct",     32'(ifc.Funct),     32'(iss[5:0]));
        chk("Imm",       32'(ifc.Imm),       32'(iss[15:0]));
        chk("PC",        ifc.PC,             m_pc);
        chk("PCPlus4",   ifc.PCPlus4,        m_pc + 32'd4);
        chk("InstAddr",  32'(ifc.InstAddr),  (m_pc / 4) % 1024);
        chk("Halted",    32'(ifc.Halted),    32'(m_halt));
        chk("HaltCause", 32'(ifc.HaltCause), 32'(m_cause));
        chk("InstCount", ifc.InstCount,      m_cnt);
    endtask

    task automatic model_step();
        logic [31:0] pc4, npc;
        int off;
        pc4 = m_pc + 32'd4;
        off = int'($signed(ifc.InstData[15:0]));
        if (ifc.JumpReg)       npc = ifc.RegRs;
        else if (ifc.Jump)     npc = (pc4 & 32'hF000_0000) | ((ifc.InstData & 32'h03FF_FFFF) * 4);
        else if ((ifc.BranchEq && ifc.Zero) || (ifc.BranchNeq && !ifc.Zero))
                               npc = pc4 + 32'(off * 4);
        else                   npc = pc4;
        if (rst) begin
            m_pc = 32'h0; m_cnt = 0; m_halt = 1'b0; m_cause = 2'd0;
        end else if (!ifc.Stall && !m_halt) begin
            if (ifc.InvalidInst) begin
                m_halt = 1'b1; m_cause = 2'd1;
            end else if (ifc.JumpReg && (ifc.RegRs % 4) != 0) begin
                m_halt = 1'b1; m_cause = 2'd2;
            end else begin
                m_pc = npc;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic step();
        #1 check_comb();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        m_pc = 0; m_cnt = 0; m_halt = 0; m_cause = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, ADD);
        @(posedge clk); model_step(); @(negedge clk);
        chk("reset_PC", ifc.PC, 32'h0);
        chk("reset_Halted", 32'(ifc.Halted), 32'h0);
        chk("reset_HaltCause", 32'(ifc.HaltCause), 32'h0);
        chk("reset_InstCount", ifc.InstCount, 32'h0);
        #1;
        chk("reset_field_Rs", 32'(ifc.Rs), 32'd8);
        chk("reset_field_Rt", 32'(ifc.Rt), 32'd9);
        chk("reset_field_Rd", 32'(ifc.Rd), 32'd10);
        chk("reset_field_Funct", 32'(ifc.Funct), 32'h20);

        //               rst s beq bne j jr inv z  rs            inst   pc             h  c  cnt
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h4,         0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h8,         0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'hC,         0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h10,        0, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0,            BEQM, 32'hC,         0, 0, 5));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,            BEQM, 32'h10,        0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            BNE4, 32'h24,        0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,            J40,  32'h100,       0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h200,      ADD,  32'h200,       0, 0, 9));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 32'h300,      J40,  32'h300,       0, 0, 10));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h300,       0, 0, 10));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0,            ADD,  32'h300,       0, 0, 10));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 32'h202,      ADD,  32'h300,       0, 0, 10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h202,      ADD,  32'h300,       1, 2, 10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h300,       1, 2, 10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h0,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h4,         0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h8,         0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0,            ADD,  32'h8,         1, 1, 2));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,        ADD,  32'h8,         1, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h0,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h1,        ADD,  32'h0,         1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h0,         0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, ADD, 32'hFFFF_FFFC, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            ADD,  32'h0,         0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0,            BNE4, 32'h4,         0, 0, 3));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].beq, tbl[i].bne, tbl[i].j, tbl[i].jr,
                  tbl[i].inv, tbl[i].zero, tbl[i].rs, tbl[i].inst);
            step();
            chk($sformatf("vec%0d_PC", i), ifc.PC, tbl[i].e_pc);
            chk($sformatf("vec%0d_Halted", i), 32'(ifc.Halted), 32'(tbl[i].e_halt));
            chk($sformatf("vec%0d_HaltCause", i), 32'(ifc.HaltCause), 32'(tbl[i].e_cause));
            chk($sformatf("vec%0d_InstCount", i), ifc.InstCount, tbl[i].e_cnt);
        end

        // Counter saturation with a preloaded value
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, ADD);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ADD);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        step();
        chk("sat_InstCount", ifc.InstCount, 32'hFFFF_FFFF);
        chk("sat_PC", ifc.PC, 32'h4);
        step();
        chk("sat_InstCount2", ifc.InstCount, 32'hFFFF_FFFF);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rs;
            rs = $urandom();
            if ($urandom_range(3) != 0) rs[1:0] = 2'b00;
            drive($urandom_range(39) == 0, $urandom_range(7) == 0,
                  $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(7) == 0, $urandom_range(7) == 0,
                  $urandom_range(31) == 0, 1'($urandom_range(1)),
                  rs, $urandom());
            step();
        end
        #1 check_comb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
